prewish5k_inputs: RTL and testbench

PREWISH5K_INPUTS -- requirements
Module: prewish5k_inputs

---
 rtl/prewish5k_pkg.sv | 16 +
 rtl/prewish5k_debounce_bit.sv | 53 +++++
 rtl/prewish5k_inputs.sv | 85 ++++++++
 tb/tb_prewish5k_inputs.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prewish5k_pkg.sv
// Shared constants and types for the prewish5k input block.
package prewish5k_pkg;

  localparam int unsigned DATA_W                 = 8;
  localparam int unsigned DEF_DEBOUNCE_TICK_BITS = 16;
  localparam int unsigned DEF_STABLE_TICKS       = 3;
  // Width of the per-bit run counter; covers STABLE_TICKS up to 15.
  localparam int unsigned STABLE_CNT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RESP = 2'b01,
    ST_ACK  = 2'b10
  } hs_state_t;

endpackage

// File: rtl/prewish5k_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a tick-sampled debouncer.
import prewish5k_pkg::*;

module prewish5k_debounce_bit #(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic deb_next
);

  localparam logic [STABLE_CNT_W-1:0] CNT_LAST = STABLE_CNT_W'(STABLE_TICKS - 1);

  logic                    sync1;
  logic                    sync2;
  logic                    deb;
  logic [STABLE_CNT_W-1:0] cnt;
  logic [STABLE_CNT_W-1:0] cnt_next;

  // Next debounced state; exported so a same-cycle update is visible to the reader.
  always_comb begin
    deb_next = deb;
    cnt_next = cnt;
    if (tick) begin
      if (sync2 == deb) begin
        cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
        deb_next = sync2;
        cnt_next = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Synchronizer chain and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: rtl/prewish5k_inputs.sv
// Debounced button/DIP inputs served over a strobe/ack request interface.
import prewish5k_pkg::*;

module prewish5k_inputs #(
  parameter int unsigned DEBOUNCE_TICK_BITS = DEF_DEBOUNCE_TICK_BITS,
  parameter int unsigned STABLE_TICKS       = DEF_STABLE_TICKS,
  parameter int unsigned ALIVE_BITS         = 22
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [DATA_W-1:0] DAT_I,
  output logic              STB_O,
  output logic [DATA_W-1:0] DAT_O,
  input  logic [DATA_W-1:0] i_raw,
  output logic              o_alive
);

  logic [DEBOUNCE_TICK_BITS-1:0] tick_cnt;
  logic                          tick;
  logic [ALIVE_BITS-1:0]         alive_cnt;
  logic [DATA_W-1:0]             deb_next;
  logic [DATA_W-1:0]             mask;
  hs_state_t                     state;

  assign tick    = &tick_cnt;
  assign o_alive = alive_cnt[ALIVE_BITS-1];

  // Free-running sample-tick and alive counters.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tick_cnt  <= '0;
      alive_cnt <= '0;
    end else begin
      tick_cnt  <= tick_cnt + 1'b1;
      alive_cnt <= alive_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    prewish5k_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk     (CLK_I),
      .rst     (RST_I),
      .tick    (tick),
      .raw     (i_raw[i]),
      .deb_next(deb_next[i])
    );
  end

  // Request handshake: latch mask, respond with masked state, then ack low.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= ST_IDLE;
      mask  <= '0;
      DAT_O <= '0;
      STB_O <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          STB_O <= 1'b0;
          if (STB_I) begin
            mask  <= DAT_I;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          DAT_O <= deb_next & mask;
          STB_O <= 1'b1;
          state <= ST_ACK;
        end
        ST_ACK: begin
          STB_O <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          STB_O <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prewish5k_inputs.sv
// Bench for prewish5k_inputs with a behavioural reference model.
module tb_prewish5k_inputs;

  localparam int TICK_BITS = 2;
  localparam int STABLE    = 3;
  localparam int ALIVE_W   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb_i;
  logic [7:0] dat_i;
  logic [7:0] raw;
  logic       stb_o;
  logic [7:0] dat_o;
  logic       alive;

  always #5 clk = ~clk;

  prewish5k_inputs #(
    .DEBOUNCE_TICK_BITS(TICK_BITS),
    .STABLE_TICKS      (STABLE),
    .ALIVE_BITS        (ALIVE_W)
  ) dut (
    .CLK_I  (clk),
    .RST_I  (rst),
    .STB_I  (stb_i),
    .DAT_I  (dat_i),
    .STB_O  (stb_o),
    .DAT_O  (dat_o),
    .i_raw  (raw),
    .o_alive(alive)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses[$];

  // Reference model state
  logic [7:0] m_hist[2];
  logic [7:0] m_deb;
  logic [7:0] m_mask;
  int         m_run[8];
  int         m_phase;
  int         m_alive;
  int         m_hold;
  bit         m_resp_due;
  logic       exp_stb;
  logic [7:0] exp_dat;
  logic       exp_alive;

  // Model advanced on every rising edge from the inputs driven at the prior falling edge.
  always @(posedge clk) begin
    logic [7:0] s;
    if (rst) begin
      m_hist[0] = '0; m_hist[1] = '0;
      m_deb = '0; m_mask = '0;
      for (int b = 0; b < 8; b++) m_run[b] = 0;
      m_phase = 0; m_alive = 0; m_hold = 0; m_resp_due = 0;
      exp_stb = 1'b0; exp_dat = '0;
    end else begin
      s = m_hist[0];
      m_hist[0] = m_hist[1];
      m_hist[1] = raw;
      if (m_phase == (1 << TICK_BITS) - 1) begin
        for (int b = 0; b < 8; b++) begin
          if (s[b] == m_deb[b]) m_run[b] = 0;
          else begin
            m_run[b] = m_run[b] + 1;
            if (m_run[b] == STABLE) begin
              m_deb[b] = s[b];
              m_run[b] = 0;
            end
          end
        end
      end
      m_phase = (m_phase + 1) % (1 << TICK_BITS);
      m_alive = (m_alive + 1) % (1 << ALIVE_W);
      if (m_resp_due) begin
        exp_stb = 1'b1;
        exp_dat = m_deb & m_mask;
        m_resp_due = 0;
      end else begin
        exp_stb = 1'b0;
      end
      if (m_hold > 0) m_hold = m_hold - 1;
      else if (stb_i) begin
        m_mask = dat_i;
        m_resp_due = 1;
        m_hold = 2;
      end
    end
    exp_alive = (m_alive >= (1 << (ALIVE_W - 1)));
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    chk("stb_o_model", 8'(stb_o), 8'(exp_stb));
    chk("dat_o_model", dat_o, exp_dat);
    chk("alive_model", 8'(alive), 8'(exp_alive));
    if (stb_o === 1'b1) pulses.push_back(cyc);
  endtask

  initial begin
    rst = 1'b1; stb_i = 1'b0; dat_i = '0; raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_stb", 8'(stb_o), 8'h00);
    chk("reset_dat", dat_o, 8'h00);
    chk("reset_alive", 8'(alive), 8'h00);

    // First request right after reset release, raw inputs low
    rst = 1'b0; stb_i = 1'b1; dat_i = 8'hFF;
    step();
    chk("first_n1_stb", 8'(stb_o), 8'h00);
    stb_i = 1'b0;
    step();
    chk("first_n2_stb", 8'(stb_o), 8'h01);
    chk("first_n2_dat", dat_o, 8'h00);
    step();
    chk("first_n3_stb", 8'(stb_o), 8'h00);

    // Hold 8'h81 long enough to debounce, then ask for bit 0
    raw = 8'h81;
    repeat (16) step();
    stb_i = 1'b1; dat_i = 8'h01;
    step();
    stb_i = 1'b0;
    step();
    chk("hold81_stb", 8'(stb_o), 8'h01);
    chk("hold81_dat", dat_o, 8'h01);
    step();

    // Settle low, then chatter bit 0 every 5 clocks: it must not debounce high
    raw = 8'h00;
    repeat (20) step();
    for (int i = 0; i < 12; i++) begin
      raw[0] = ~raw[0];
      repeat (5) step();
    end
    stb_i = 1'b1; dat_i = 8'hFF;
    step();
    stb_i = 1'b0;
    step();
    chk("chatter_stb", 8'(stb_o), 8'h01);
    chk("chatter_bit0", 8'(dat_o[0]), 8'h00);
    step();

    // STB_I held for 9 clocks gives three pulses, 3 clocks apart
    pulses.delete();
    stb_i = 1'b1; dat_i = 8'($urandom);
    repeat (9) step();
    stb_i = 1'b0;
    repeat (3) step();
    chk("held_pulse_count", 8'(pulses.size()), 8'd3);
    if (pulses.size() == 3) begin
      chk("held_spacing_a", 8'(pulses[1] - pulses[0]), 8'd3);
      chk("held_spacing_b", 8'(pulses[2] - pulses[1]), 8'd3);
    end

    // Reset while in RESP aborts the response; IDLE accepts right after
    stb_i = 1'b1; dat_i = 8'hFF;
    step();
    stb_i = 1'b0; rst = 1'b1;
    step();
    chk("abort_stb", 8'(stb_o), 8'h00);
    chk("abort_dat", dat_o, 8'h00);
    rst = 1'b0; stb_i = 1'b1; dat_i = 8'hFF;
    step();
    chk("after_abort_n1_stb", 8'(stb_o), 8'h00);
    stb_i = 1'b0;
    step();
    chk("after_abort_n2_stb", 8'(stb_o), 8'h01);
    step();

    // 8'h55 masked by 8'h0F, then DAT_O holds while inputs wander
    raw = 8'h55;
    repeat (16) step();
    stb_i = 1'b1; dat_i = 8'h0F;
    step();
    stb_i = 1'b0;
    step();
    chk("mask55_stb", 8'(stb_o), 8'h01);
    chk("mask55_dat", dat_o, 8'h05);
    for (int i = 0; i < 10; i++) begin
      raw = 8'($urandom);
      step();
      chk("mask55_hold", dat_o, 8'h05);
    end

    // Randomised traffic checked every cycle against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) raw = 8'($urandom);
      stb_i = ($urandom_range(0, 3) == 0);
      dat_i = 8'($urandom);
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      else rst = 1'b0;
      step();
    end
    rst = 1'b0; stb_i = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
